// File: rtl/commu_m_pkg.sv
// Shared types and constants for the master-side communication read channel.
package commu_m_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REAL = 2'd1,
        ST_TP   = 2'd2
    } state_e;

    // Source of the byte returned one cycle after an accepted read.
    typedef enum logic [1:0] {
        SRC_TP   = 2'd0,
        SRC_REAL = 2'd1,
        SRC_FILL = 2'd2
    } src_e;

    localparam int unsigned CFG_RUN_BIT = 0;
    localparam int unsigned CFG_TP_BIT  = 1;

    // State selected by the configuration word at a frame boundary or from idle.
    function automatic state_e cfg_next_state(input logic [7:0] cfg);
        if (!cfg[CFG_RUN_BIT]) begin
            return ST_IDLE;
        end
        return cfg[CFG_TP_BIT] ? ST_TP : ST_REAL;
    endfunction

endpackage

// File: rtl/commu_m_arb_stat.sv
// Saturating frame/underflow statistics for commu_m_arb.
// Present only when COMMU_M_ARB_STAT_EN is defined.
`ifdef COMMU_M_ARB_STAT_EN
module commu_m_arb_stat (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        frm_real_inc,
    input  logic        frm_tp_inc,
    input  logic        unf_inc,
    output logic [15:0] stat_frm_real,
    output logic [15:0] stat_frm_tp,
    output logic [15:0] stat_unf
);

    logic [15:0] frm_real_q, frm_real_d;
    logic [15:0] frm_tp_q,   frm_tp_d;
    logic [15:0] unf_q,      unf_d;

    // Increment each counter on its event pulse, holding at all-ones.
    always_comb begin
        frm_real_d = frm_real_q;
        frm_tp_d   = frm_tp_q;
        unf_d      = unf_q;
        if (frm_real_inc && (frm_real_q != '1)) frm_real_d = frm_real_q + 16'd1;
        if (frm_tp_inc   && (frm_tp_q   != '1)) frm_tp_d   = frm_tp_q   + 16'd1;
        if (unf_inc      && (unf_q      != '1)) unf_d      = unf_q      + 16'd1;
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            frm_real_q <= '0;
            frm_tp_q   <= '0;
            unf_q      <= '0;
        end else begin
            frm_real_q <= frm_real_d;
            frm_tp_q   <= frm_tp_d;
            unf_q      <= unf_d;
        end
    end

    assign stat_frm_real = frm_real_q;
    assign stat_frm_tp   = frm_tp_q;
    assign stat_unf      = unf_q;

endmodule
`endif

// File: rtl/commu_m_arb.sv
// Frame-aligned source arbiter: real FIFO or test-pattern source, switched
// only on frame boundaries, padding real-source underflow with FILL_BYTE.
// Optional statistics outputs under COMMU_M_ARB_STAT_EN.
module commu_m_arb
    import commu_m_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 256,
    parameter logic [7:0]  FILL_BYTE = 8'h00
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  cfg_tp,
    input  logic        req_rd,
    output logic [7:0]  req_q,
    output logic        req_vld,
    output logic        req_sof,
    output logic        real_rd,
    input  logic [7:0]  real_q,
    input  logic        real_empty,
    output logic        tp_rd,
    input  logic [7:0]  tp_q
`ifdef COMMU_M_ARB_STAT_EN
    ,
    output logic [15:0] stat_frm_real,
    output logic [15:0] stat_frm_tp,
    output logic [15:0] stat_unf
`endif
);

    localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          vld_q,   vld_d;
    logic          sof_q,   sof_d;
    src_e          src_q,   src_d;
    logic          accept;

    logic unused_cfg;
    assign unused_cfg = ^cfg_tp[7:2];

    // Next-state, byte counter, source strobes and registered read tag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
        src_d   = src_q;
        accept  = 1'b0;
        real_rd = 1'b0;
        tp_rd   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = cfg_next_state(cfg_tp);
            end
            ST_REAL: begin
                accept  = req_rd;
                real_rd = req_rd & ~real_empty;
            end
            ST_TP: begin
                accept = req_rd;
                tp_rd  = req_rd;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            vld_d = 1'b1;
            sof_d = (cnt_q == '0);
            if (state_q == ST_TP) src_d = SRC_TP;
            else                  src_d = real_empty ? SRC_FILL : SRC_REAL;
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = cfg_next_state(cfg_tp);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State and read-pipeline registers.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            src_q   <= SRC_TP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            src_q   <= src_d;
        end
    end

    // Return-data mux steered by the tag captured with the accepted read.
    always_comb begin
        req_q = FILL_BYTE;
        if (vld_q) begin
            case (src_q)
                SRC_TP:   req_q = tp_q;
                SRC_REAL: req_q = real_q;
                default:  req_q = FILL_BYTE;
            endcase
        end
    end

    assign req_vld = vld_q;
    assign req_sof = sof_q;

`ifdef COMMU_M_ARB_STAT_EN
    logic frm_end;
    assign frm_end = accept & (cnt_q == CNT_LAST);

    commu_m_arb_stat u_stat (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .frm_real_inc  (frm_end & (state_q == ST_REAL)),
        .frm_tp_inc    (frm_end & (state_q == ST_TP)),
        .unf_inc       ((state_q == ST_REAL) & req_rd & real_empty),
        .stat_frm_real (stat_frm_real),
        .stat_frm_tp   (stat_frm_tp),
        .stat_unf      (stat_unf)
    );
`endif

endmodule

// File: tb/tb_commu_m_arb.sv
// Directed table-driven bench for commu_m_arb with FRAME_LEN = 4.
module tb_commu_m_arb;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cfg_tp = 8'h00;
    logic       req_rd = 1'b0;
    logic [7:0] req_q;
    logic       req_vld;
    logic       req_sof;
    logic       real_rd;
    logic [7:0] real_q = 8'h00;
    logic       real_empty = 1'b0;
    logic       tp_rd;
    logic [7:0] tp_q = 8'h00;
`ifdef COMMU_M_ARB_STAT_EN
    logic [15:0] stat_frm_real, stat_frm_tp, stat_unf;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk_sys = ~clk_sys;

    commu_m_arb #(.FRAME_LEN(4), .FILL_BYTE(8'h00)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .cfg_tp     (cfg_tp),
        .req_rd     (req_rd),
        .req_q      (req_q),
        .req_vld    (req_vld),
        .req_sof    (req_sof),
        .real_rd    (real_rd),
        .real_q     (real_q),
        .real_empty (real_empty),
        .tp_rd      (tp_rd),
        .tp_q       (tp_q)
`ifdef COMMU_M_ARB_STAT_EN
        ,
        .stat_frm_real (stat_frm_real),
        .stat_frm_tp   (stat_frm_tp),
        .stat_unf      (stat_unf)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic [7:0] cfg;
        logic       rd;
        logic [7:0] rq;
        logic       re;
        logic [7:0] tq;
        logic       e_rr;
        logic       e_tr;
        logic       e_vld;
        logic       e_sof;
        logic [7:0] e_q;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] c, input logic rd, input logic [7:0] rq,
                       input logic re, input logic [7:0] tq, input logic err, input logic etr,
                       input logic evld, input logic esof, input logic [7:0] eq);
        vec_t v;
        v.rst_n = r; v.cfg = c; v.rd = rd; v.rq = rq; v.re = re; v.tq = tq;
        v.e_rr = err; v.e_tr = etr; v.e_vld = evld; v.e_sof = esof; v.e_q = eq;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h, want %h", name, idx, got, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, settle before the rising edge.
    task automatic cyc(input logic r, input logic [7:0] c, input logic rd, input logic re,
                       input logic [7:0] rq, input logic [7:0] tq);
        @(negedge clk_sys);
        rst_n = r; cfg_tp = c; req_rd = rd; real_empty = re; real_q = rq; tp_q = tq;
        #4;
    endtask

    initial begin
        // reset, idle ignores reads
        add(0,8'h00,0,8'h11,0,8'h22, 0,0,0,0,8'h00);
        add(0,8'h00,1,8'h11,0,8'h22, 0,0,0,0,8'h00);
        add(1,8'h00,1,8'h12,0,8'h23, 0,0,0,0,8'h00);
        add(1,8'h00,1,8'h13,0,8'h24, 0,0,0,0,8'h00);
        add(1,8'h00,0,8'h14,0,8'h25, 0,0,0,0,8'h00);
        // test pattern, 8 continuous reads
        add(1,8'h03,0,8'h20,0,8'hA5, 0,0,0,0,8'h00);
        add(1,8'h03,1,8'h21,0,8'hA5, 0,1,0,0,8'h00);
        add(1,8'h03,1,8'h22,0,8'hA5, 0,1,1,1,8'hA5);
        add(1,8'h03,1,8'h23,0,8'hA5, 0,1,1,0,8'hA5);
        add(1,8'h03,1,8'h24,0,8'hA5, 0,1,1,0,8'hA5);
        add(1,8'h03,1,8'h25,0,8'hA5, 0,1,1,0,8'hA5);
        add(1,8'h03,1,8'h26,0,8'hA5, 0,1,1,1,8'hA5);
        add(1,8'h03,1,8'h27,0,8'hA5, 0,1,1,0,8'hA5);
        add(1,8'h03,1,8'h28,0,8'hA5, 0,1,1,0,8'hA5);
        add(1,8'h03,0,8'h29,0,8'hA5, 0,0,1,0,8'hA5);
        add(0,8'h03,0,8'h2A,0,8'hA5, 0,0,0,0,8'h00);
        // real, switch to tp requested mid-frame
        add(1,8'h01,0,8'h30,0,8'hA0, 0,0,0,0,8'h00);
        add(1,8'h01,1,8'h31,0,8'hA1, 1,0,0,0,8'h00);
        add(1,8'h01,1,8'h32,0,8'hA2, 1,0,1,1,8'h32);
        add(1,8'h03,1,8'h33,0,8'hA3, 1,0,1,0,8'h33);
        add(1,8'h03,1,8'h34,0,8'hA4, 1,0,1,0,8'h34);
        add(1,8'h03,1,8'h35,0,8'hB5, 0,1,1,0,8'h35);
        add(1,8'h03,1,8'h36,0,8'hB6, 0,1,1,1,8'hB6);
        add(1,8'h03,0,8'h37,0,8'hB7, 0,0,1,0,8'hB7);
        add(0,8'h00,0,8'h38,0,8'hB8, 0,0,0,0,8'h00);
        // real underflow on reads 1-2
        add(1,8'h01,0,8'h40,0,8'hC0, 0,0,0,0,8'h00);
        add(1,8'h01,1,8'h41,0,8'hC1, 1,0,0,0,8'h00);
        add(1,8'h01,1,8'h42,1,8'hC2, 0,0,1,1,8'h42);
        add(1,8'h01,1,8'h43,1,8'hC3, 0,0,1,0,8'h00);
        add(1,8'h01,1,8'h44,0,8'hC4, 1,0,1,0,8'h00);
        add(1,8'h01,1,8'h45,0,8'hC5, 1,0,1,0,8'h45);
        add(1,8'h01,0,8'h46,0,8'hC6, 0,0,1,1,8'h46);
        add(0,8'h00,0,8'h47,0,8'hC7, 0,0,0,0,8'h00);
        // run cleared at byte 1, underflow on the last byte, then idle
        add(1,8'h01,0,8'h50,0,8'hD0, 0,0,0,0,8'h00);
        add(1,8'h01,1,8'h51,0,8'hD1, 1,0,0,0,8'h00);
        add(1,8'h00,1,8'h52,0,8'hD2, 1,0,1,1,8'h52);
        add(1,8'h00,1,8'h53,0,8'hD3, 1,0,1,0,8'h53);
        add(1,8'h00,1,8'h54,1,8'hD4, 0,0,1,0,8'h54);
        add(1,8'h00,1,8'h55,0,8'hD5, 0,0,1,0,8'h00);
        add(1,8'h00,1,8'h56,0,8'hD6, 0,0,0,0,8'h00);
        add(1,8'h00,0,8'h57,0,8'hD7, 0,0,0,0,8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst_n, vecs[i].cfg, vecs[i].rd, vecs[i].re, vecs[i].rq, vecs[i].tq);
            chk("real_rd", i, 16'(real_rd), 16'(vecs[i].e_rr));
            chk("tp_rd",   i, 16'(tp_rd),   16'(vecs[i].e_tr));
            chk("req_vld", i, 16'(req_vld), 16'(vecs[i].e_vld));
            chk("req_sof", i, 16'(req_sof), 16'(vecs[i].e_sof));
            chk("req_q",   i, 16'(req_q),   16'(vecs[i].e_q));
        end

        // reset in mid-frame with req_rd held high
        cyc(1, 8'h03, 0, 0, 8'h60, 8'hA5);
        cyc(1, 8'h03, 1, 0, 8'h61, 8'hA5);
        chk("mid_tp_rd", 100, 16'(tp_rd), 16'd1);
        cyc(1, 8'h03, 1, 0, 8'h62, 8'hA5);
        chk("mid_vld", 101, 16'(req_vld), 16'd1);
        cyc(0, 8'h03, 1, 0, 8'h63, 8'hA5);
        cyc(1, 8'h00, 1, 0, 8'h64, 8'hA5);
        chk("rst_vld",   102, 16'(req_vld), 16'd0);
        chk("rst_tp_rd", 103, 16'(tp_rd),   16'd0);
        chk("rst_req_q", 104, 16'(req_q),   16'h00);
        cyc(1, 8'h03, 1, 0, 8'h65, 8'hA5);
        chk("idle_tp_rd", 105, 16'(tp_rd),   16'd0);
        chk("idle_vld",   106, 16'(req_vld), 16'd0);
        cyc(1, 8'h03, 1, 0, 8'h66, 8'h77);
        chk("restart_tp_rd", 107, 16'(tp_rd), 16'd1);
        cyc(1, 8'h03, 0, 0, 8'h67, 8'h78);
        chk("restart_vld", 108, 16'(req_vld), 16'd1);
        chk("restart_sof", 109, 16'(req_sof), 16'd1);
        chk("restart_q",   110, 16'(req_q),   16'h78);

`ifdef COMMU_M_ARB_STAT_EN
        cyc(0, 8'h00, 0, 0, 8'h70, 8'h00);
        cyc(1, 8'h01, 0, 0, 8'h70, 8'h00);
        cyc(1, 8'h01, 1, 0, 8'h71, 8'h00);
        cyc(1, 8'h01, 1, 1, 8'h72, 8'h00);
        cyc(1, 8'h01, 1, 1, 8'h73, 8'h00);
        cyc(1, 8'h01, 1, 0, 8'h74, 8'h00);
        cyc(1, 8'h01, 0, 0, 8'h75, 8'h00);
        chk("stat_unf",      200, stat_unf,      16'd2);
        chk("stat_frm_real", 201, stat_frm_real, 16'd1);
        chk("stat_frm_tp",   202, stat_frm_tp,   16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commu_m_arb.md
# commu_m_arb

Frame-aligned source arbiter for the master-side communication read channel. It gives the downstream byte requester access to either the real-data FIFO or the test-pattern generator. Source changes take effect only on frame boundaries, so no frame ever mixes sources. If the real FIFO runs dry, the block pads with a fill byte so frames stay aligned.

## Interface
Parameters:
- FRAME_LEN, 256: bytes per frame; legal range 2..65536.
- FILL_BYTE, 8'h00: byte substituted when the real source underflows.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- cfg_tp  in  8  configuration. Bit 0 = run enable. Bit 1 = test-pattern select (1 = tp, 0 = real). Bits 7:2 are reserved and ignored.
- req_rd  in  1  requester byte read strobe, one byte per asserted cycle.
- req_q  out  8  returned byte, valid when req_vld = 1.
- req_vld  out  1  req_q valid.
- req_sof  out  1  marks the first byte of a frame; qualified by req_vld.
- real_rd  out  1  read strobe to the real FIFO.
- real_q  in  8  real FIFO data, valid the cycle after real_rd.
- real_empty  in  1  real FIFO empty.
- tp_rd  out  1  read strobe to the test-pattern source.
- tp_q  in  8  pattern data, valid the cycle after tp_rd.

## Operation
- FSM states: ST_IDLE, ST_REAL, ST_TP. Reset enters ST_IDLE.
- ST_IDLE:
  - req_rd is ignored: no source read, req_vld stays 0.
  - When cfg_tp[0] = 1, the next state is ST_TP if cfg_tp[1] = 1, otherwise ST_REAL.
  - The byte counter is cleared to 0.
- Byte counter:
  - Width is clog2(FRAME_LEN).
  - Increments on every accepted req_rd in ST_REAL or ST_TP.
  - Wraps from FRAME_LEN-1 to 0.
- Frame boundary: an accepted req_rd with counter = FRAME_LEN-1. On that cycle cfg_tp is re-sampled:
  - bit 0 = 0 → ST_IDLE.
  - otherwise → ST_TP or ST_REAL according to bit 1.
  - Re-entering the same state is allowed.
- cfg_tp changes in mid-frame have no effect until the boundary.
- ST_TP: tp_rd = req_rd; real_rd = 0.
- ST_REAL:
  - real_rd = req_rd & ~real_empty; tp_rd = 0.
  - Underflow = req_rd & real_empty. On underflow the byte still counts, and FILL_BYTE is returned in place of FIFO data.
- Source read strobes are combinational from req_rd and the state; they never assert in ST_IDLE.

## Timing
- Latency: req_rd accepted at cycle N → req_vld = 1 at N+1.
- Data path at N+1:
  - req_q is a combinational mux of tp_q, real_q or FILL_BYTE.
  - The mux is steered by a source tag registered at N.
- req_sof at N+1 is 1 when the counter was 0 at N.
- Back-to-back req_rd gives one byte per cycle with no bubbles, including across a frame boundary with a source switch.
- Reset values: state = ST_IDLE, counter = 0, req_vld = 0, req_sof = 0, source tag = tp.
  - req_q = FILL_BYTE while req_vld = 0.
  - real_rd = tp_rd = 0.
- Reset in mid-frame aborts the frame; a read in flight produces no req_vld.
- Underflow on the last byte of a frame still counts as the boundary.
- cfg_tp[0] falling in mid-frame: the current frame completes normally.

## Configuration
- COMMU_M_ARB_STAT_EN defined adds three output ports, all reset to 0:
  - stat_frm_real (16 b): completed real frames, saturating.
  - stat_frm_tp (16 b): completed tp frames, saturating.
  - stat_unf (16 b): underflow bytes, saturating.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package commu_m_pkg holds:
  - the state encoding typedef (ST_IDLE/ST_REAL/ST_TP);
  - the source tag typedef;
  - the cfg_tp bit-index constants CFG_RUN_BIT = 0 and CFG_TP_BIT = 1.
- Sub-module commu_m_arb_stat holds the saturating counters and is instantiated only under COMMU_M_ARB_STAT_EN.

## Test plan
- Reset with cfg_tp = 0, then pulse req_rd → real_rd = tp_rd = 0, req_vld stays 0, req_q = 8'h00.
- FRAME_LEN = 4, cfg_tp = 8'h03, 8 continuous reads with tp_q = 8'hA5 → 8 bytes of A5 on consecutive cycles; req_sof on bytes 0 and 4; real_rd never asserts.
- FRAME_LEN = 4, cfg_tp = 8'h01:
  - After 2 reads, set cfg_tp = 8'h03.
  - Required: bytes 2–3 still come from real_q; bytes 4 onward come from tp_q, with no gap.
- ST_REAL with real_empty = 1 for reads 1–2 of a frame → real_rd = 0 on those cycles and req_q = FILL_BYTE; the frame still ends after 4 bytes; with the macro, stat_unf = 2.
- Clear cfg_tp[0] at byte 1 → frame finishes at byte 3; the next req_rd gives no strobes and no req_vld (ST_IDLE).
- Assert rst_n = 0 for one cycle in mid-frame with req_rd held high → req_vld = 0 on the following cycle; state is ST_IDLE; counter = 0.
